// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator
//   Bus master for the memory / memory-mapped IO bus. A client posts single
//   or burst read/write requests over a valid/ready handshake. The initiator
//   walks the burst one beat at a time. Each read command is held on the bus
//   for READ_LAT+1 cycles before read_data is captured, and read data goes
//   back to the client on a back-pressured response channel.
//
// Ports
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (accepted only while idle)
//   req_write            1 = write burst, 0 = read burst
//   req_addr, req_len    first beat address, beats minus one
//   wr_valid/wr_ready    write beat handshake, wr_data passed straight to bus
//   rsp_valid/rsp_ready  read beat handshake; rsp_data, rsp_last held while stalled
//   busy                 a burst is in progress
//   mem_cmd              2'b10 MREAD, 2'b01 MWRITE, 2'b00 none
//   mem_addr, write_data bus address and write data (zero when no command)
//   read_data            bus read data returned by the slaves

module mem_bus_initiator #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int LEN_W    = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  // Value of the wait counter on the last cycle of a read command.
  localparam logic [1:0] LAT_LAST  = 2'(READ_LAT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_ISSUE = 2'd2,
    RD_RSP   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beat_cnt;
  logic [1:0]        wait_cnt;
  logic              accept_req;
  logic              write_beat;
  logic              rsp_next;

  // Addresses wrap modulo 2^ADDR_W; any carry out is discarded.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  assign accept_req = (state == IDLE) && req_valid;
  assign write_beat = (state == WRITE) && wr_valid;
  // A non-final read beat is accepted, so the next beat begins.
  assign rsp_next   = (state == RD_RSP) && rsp_ready && !rsp_last;

  assign req_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);

  // Bus drive: write beats pass wr_data straight through in the cycle the
  // client presents it; the bus is quiet in IDLE and while a response waits.
  always_comb begin
    mem_cmd    = CMD_NONE;
    mem_addr   = '0;
    write_data = '0;
    case (state)
      WRITE: begin
        if (wr_valid) begin
          mem_cmd    = CMD_WRITE;
          mem_addr   = cur_addr;
          write_data = wr_data;
        end
      end
      RD_ISSUE: begin
        mem_cmd  = CMD_READ;
        mem_addr = cur_addr;
      end
      default: ;
    endcase
  end

  // Beat address; only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept_req) begin
      cur_addr <= req_addr;
    end else if ((write_beat && (beat_cnt != '0)) || rsp_next) begin
      cur_addr <= addr_inc(cur_addr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            beat_cnt <= req_len;
            wait_cnt <= '0;
            state    <= req_write ? WRITE : RD_ISSUE;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            if (beat_cnt == '0) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt - LEN_W'(1);
            end
          end
        end
        RD_ISSUE: begin
          // Hold the read command READ_LAT+1 cycles, capture on the last edge.
          if (wait_cnt == LAT_LAST) begin
            wait_cnt  <= '0;
            rsp_data  <= read_data;
            rsp_valid <= 1'b1;
            rsp_last  <= (beat_cnt == '0);
            state     <= RD_RSP;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RD_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              rsp_last <= 1'b0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt - LEN_W'(1);
              state    <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
